// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Initiator side of a byte-wide synchronous data memory. Takes one byte, half
// or word load/store from the CPU load/store path and breaks it into
// single-byte accesses. Big-endian: the byte at the base address is the most
// significant byte of the value. Loads are sign- or zero-extended to 32 bits.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the memory entirely and
//               complete with Done=1, Err=1 in the cycle after acceptance.
//   undefined : Err is tied low; misaligned accesses run at the given address.
//
// Ports
//   CLK       in   clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Req       in   request strobe, sampled only while Ready=1
//   RW        in   1 = store, 0 = load
//   Size      in   00 byte, 01 half, 10/11 word
//   Unsigned  in   loads: 1 = zero-extend, 0 = sign-extend
//   Addr      in   base byte address (ADDR_W bits)
//   WData     in   store data, right-aligned
//   Ready     out  high only while idle
//   Done      out  one-cycle completion pulse
//   RData     out  last load result
//   Err       out  misalignment flag (see macro above)
//   MemEn     out  byte-port enable
//   MemWE     out  byte-port write enable
//   MemAddr   out  byte-port address (ADDR_W bits)
//   MemWData  out  byte-port write data
//   MemRData  in   byte-port read data, valid one cycle after the address
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Ready,
  output logic              Done,
  output logic [31:0]       RData,
  output logic              Err,
  output logic              MemEn,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_TAIL,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        k_reg, k_next;
  logic              rw_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [23:0]       shift_reg;
  logic [31:0]       rdata_reg;

  logic              accept;
  logic              trap;
  logic              misalign;
  logic [1:0]        last_k;
  logic [1:0]        byte_sel;
  logic              capture;
  logic [31:0]       assembled;
  logic [31:0]       extended;

  // Index of the final byte cycle for the latched size.
  always_comb begin
    last_k = 2'd3;
    case (size_reg)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic err_reg;

  // Evaluated on the live inputs because the decision is made at acceptance.
  always_comb begin
    misalign = 1'b0;
    if (Size == 2'b01)
      misalign = Addr[0];
    else if (Size[1])
      misalign = (Addr[1:0] != 2'b00);
  end

  assign Err = err_reg;
`else
  assign misalign = 1'b0;
  assign Err      = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    accept     = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (Req) begin
          accept = 1'b1;
          k_next = 2'd0;
          if (misalign) begin
            trap       = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (k_reg == last_k)
          state_next = rw_reg ? S_DONE : S_TAIL;
        else
          k_next = k_reg + 2'd1;
      end
      S_TAIL:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so the byte for cycle k-1 is on
  // MemRData during cycle k (k>=1) and the last byte arrives during TAIL.
  assign capture   = ((state_reg == S_ACCESS) && (k_reg != 2'd0) && !rw_reg) ||
                     (state_reg == S_TAIL);
  assign assembled = {shift_reg, MemRData};

  always_comb begin
    extended = assembled;
    case (size_reg)
      2'b00:   extended = {{24{~uns_reg & assembled[7]}}, assembled[7:0]};
      2'b01:   extended = {{16{~uns_reg & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= S_IDLE;
      k_reg     <= 2'd0;
      rw_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      shift_reg <= 24'h0;
      rdata_reg <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
`ifdef MISALIGN_TRAP_EN
      // Set only for the single DONE cycle that follows a trapped request.
      err_reg   <= trap;
`endif
      if (accept) begin
        rw_reg    <= RW;
        size_reg  <= Size;
        uns_reg   <= Unsigned;
        addr_reg  <= Addr;
        wdata_reg <= WData;
        shift_reg <= 24'h0;
      end else if (capture) begin
        shift_reg <= {shift_reg[15:0], MemRData};
      end
      if (state_reg == S_TAIL)
        rdata_reg <= extended;
    end
  end

  // Store byte order: cycle k sends byte (N-1-k) counted from the LSB.
  assign byte_sel = last_k - k_reg;

  always_comb begin
    MemWData = 8'h00;
    if (MemWE) begin
      case (byte_sel)
        2'd0: MemWData = wdata_reg[7:0];
        2'd1: MemWData = wdata_reg[15:8];
        2'd2: MemWData = wdata_reg[23:16];
        2'd3: MemWData = wdata_reg[31:24];
        default: MemWData = 8'h00;
      endcase
    end
  end

  // All port outputs decode from state so an asynchronous reset clears them
  // in the same instant it forces IDLE.
  assign Ready   = (state_reg == S_IDLE);
  assign Done    = (state_reg == S_DONE);
  assign MemEn   = (state_reg == S_ACCESS);
  assign MemWE   = MemEn & rw_reg;
  assign MemAddr = MemEn ? (addr_reg + ADDR_W'(k_reg)) : '0;
  assign RData   = rdata_reg;

  // trap is only consumed when the misalignment feature is built in.
  logic unused_trap;
  assign unused_trap = trap;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small synchronous byte memory.
module tb_mem_access_unit;

  logic        CLK;
  logic        Reset;
  logic        Req;
  logic        RW;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Ready;
  logic        Done;
  logic [31:0] RData;
  logic        Err;
  logic        MemEn;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic       tb_clear;

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Req      (Req),
    .RW       (RW),
    .Size     (Size),
    .Unsigned (Unsigned),
    .Addr     (Addr),
    .WData    (WData),
    .Ready    (Ready),
    .Done     (Done),
    .RData    (RData),
    .Err      (Err),
    .MemEn    (MemEn),
    .MemWE    (MemWE),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRData (MemRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous byte memory: read data appears the cycle after the address.
  always @(posedge CLK) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (MemEn) begin
      if (MemWE) mem[MemAddr[7:0]] <= MemWData;
      else       MemRData <= mem[MemAddr[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction from IDLE back to IDLE, checking every cycle.
  task automatic run_txn(input string tag, input logic rw, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    chk({tag, ".ready_idle"}, 32'(Ready), 32'd1);
    Req = 1'b1; RW = rw; Size = sz; Unsigned = uns; Addr = a; WData = wd;
    tick();
    // Scramble inputs: the transaction in flight must use latched values.
    Req = 1'b0; RW = ~rw; Size = ~sz; Unsigned = ~uns; Addr = ~a; WData = ~wd;
    for (int k = 0; k < n; k++) begin
      chk({tag, ".access_ctl"}, 32'({Ready, Done, MemEn, MemWE}), 32'({3'b001, rw}));
      chk({tag, ".access_addr"}, MemAddr, a + k);
      if (rw)
        chk({tag, ".access_wdata"}, 32'(MemWData), (wd >> (8 * (n - 1 - k))) & 32'hFF);
      tick();
    end
    if (!rw) begin
      chk({tag, ".tail_ctl"}, 32'({Ready, Done, MemEn}), 32'b000);
      tick();
    end
    chk({tag, ".done_ctl"}, 32'({Ready, Done, Err, MemEn}), 32'b0100);
    chk({tag, ".rdata"}, RData, exp_rd);
    tick();
    chk({tag, ".back_idle"}, 32'({Ready, Done}), 32'b10);
    $display("txn %s rw=%0b size=%0d addr=%h wdata=%h rdata=%h", tag, rw, sz, a, wd, RData);
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic trap_txn(input string tag, input logic rw, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] exp_rd);
    Req = 1'b1; RW = rw; Size = sz; Unsigned = 1'b0; Addr = a; WData = 32'h00C0FFEE;
    tick();
    Req = 1'b0;
    chk({tag, ".trap_ctl"}, 32'({Ready, Done, Err, MemEn}), 32'b0110);
    chk({tag, ".trap_rdata"}, RData, exp_rd);
    tick();
    chk({tag, ".trap_after"}, 32'({Ready, Done, Err, MemEn}), 32'b1000);
    $display("txn %s trapped rw=%0b size=%0d addr=%h", tag, rw, sz, a);
  endtask
`endif

  logic [2:0] pat [4];

  initial begin
    pat[0] = 3'b001;  // ACCESS
    pat[1] = 3'b000;  // TAIL
    pat[2] = 3'b010;  // DONE
    pat[3] = 3'b100;  // IDLE
    Reset = 1'b0; tb_clear = 1'b1;
    Req = 1'b0; RW = 1'b0; Size = 2'b00; Unsigned = 1'b0; Addr = 32'h0; WData = 32'h0;

    // Outputs while reset is held.
    #2;
    chk("reset.ctl", 32'({Ready, Done, Err, MemEn, MemWE}), 32'b10000);
    chk("reset.rdata", RData, 32'h0);
    chk("reset.memaddr", MemAddr, 32'h0);
    chk("reset.memwdata", 32'(MemWData), 32'h0);
    tick();
    tick();
    Reset = 1'b1; tb_clear = 1'b0;
    tick();

    run_txn("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    chk("mem10", 32'(mem[8'h10]), 32'hDE);
    chk("mem11", 32'(mem[8'h11]), 32'hAD);
    chk("mem12", 32'(mem[8'h12]), 32'hBE);
    chk("mem13", 32'(mem[8'h13]), 32'hEF);

    run_txn("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    run_txn("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFBE);
    run_txn("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h000000BE);
    run_txn("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFDEAD);
    run_txn("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000BEEF);
    run_txn("st_byte", 1'b1, 2'b00, 1'b0, 32'h14, 32'hAAAAAA5A, 32'h0000BEEF);
    chk("mem14", 32'(mem[8'h14]), 32'h5A);
    run_txn("ld_size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

`ifdef MISALIGN_TRAP_EN
    trap_txn("trap_ld_word", 1'b0, 2'b10, 32'h11, 32'hDEADBEEF);
    trap_txn("trap_st_half", 1'b1, 2'b01, 32'h13, 32'hDEADBEEF);
    chk("mem13_untouched", 32'(mem[8'h13]), 32'hEF);
`else
    run_txn("ld_word_unal", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'hADBEEF5A);
    run_txn("st_half_wrap", 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00008001, 32'hADBEEF5A);
    chk("memFF", 32'(mem[8'hFF]), 32'h80);
    chk("mem00", 32'(mem[8'h00]), 32'h01);
    run_txn("ld_half_wrap", 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 32'hFFFF8001);
`endif
    run_txn("ld_byte_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAD);

    // Req held high: acceptance only from IDLE, one-cycle Done pulses.
    Req = 1'b1; RW = 1'b0; Size = 2'b00; Unsigned = 1'b0; Addr = 32'h13; WData = 32'h0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("held_req.pattern", 32'({Ready, Done, MemEn}), 32'(pat[i % 4]));
      if (i < 7) tick();
    end
    Req = 1'b0;
    chk("held_req.rdata", RData, 32'hFFFFFFEF);
    $display("txn held_req two byte loads addr=00000013 rdata=%h", RData);
    tick();

    // Reset during byte cycle k=2 of a word store.
    Req = 1'b1; RW = 1'b1; Size = 2'b10; Unsigned = 1'b0; Addr = 32'h20; WData = 32'h11223344;
    tick();
    Req = 1'b0;
    tick();
    tick();
    chk("abort.k2_addr", MemAddr, 32'h22);
    chk("abort.k2_we", 32'({MemEn, MemWE}), 32'b11);
    Reset = 1'b0;
    #1;
    chk("abort.ctl", 32'({Ready, Done, MemEn, MemWE}), 32'b1000);
    chk("abort.memaddr", MemAddr, 32'h0);
    chk("abort.rdata", RData, 32'h0);
    tick();
    Reset = 1'b1;
    tick();
    chk("abort.after", 32'({Ready, Done, MemEn}), 32'b100);
    chk("abort.mem20", 32'(mem[8'h20]), 32'h11);
    chk("abort.mem21", 32'(mem[8'h21]), 32'h22);
    chk("abort.mem22", 32'(mem[8'h22]), 32'h00);
    chk("abort.mem23", 32'(mem[8'h23]), 32'h00);
    $display("txn abort word store addr=00000020 at k=2");

    run_txn("ld_after_abort", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11220000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
